uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Receive-side frame controller for the UART RX path.
- Detects the start bit and drives the edge/bit counter enable. Consumes edge_cnt/bit_cnt and the majority-voted sampled_bit from the data sampler.
- Deserializes data LSB-first and checks parity and stop bits.
- Presents the received byte with a one-cycle data_valid pulse to downstream logic.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..8).
CNT_W, 5, width of edge_cnt/bit_cnt/prescale.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST  input  1  asynchronous active-low reset.
rx_in  input  1  serial line, idle high (already synchronized upstream).
prescale  input  CNT_W  oversampling ratio; only 8 and 16 are legal.
par_en  input  1  1 = frame carries a parity bit.
par_typ  input  1  0 = even parity, 1 = odd parity.
edge_cnt  input  CNT_W  oversample index within the current bit, 0..prescale-1.
bit_cnt  input  CNT_W  bit index in frame: 0 = start, 1..DATA_WIDTH = data.
sampled_bit  input  1  voted bit value; stable from edge_cnt = prescale/2+2 to end of bit.
cnt_enable  output  1  enable to edge/bit counter; low clears the counter.
dat_samp_en  output  1  enable to data sampler.
p_out  output  DATA_WIDTH  last good received byte.
data_valid  output  1  one-cycle pulse, p_out updated.
par_err  output  1  parity error of the last frame.
stp_err  output  1  stop error of the last frame.

Behaviour:
- Reset: every output is 0. State = IDLE. Shift register and latched config are 0. Reset is asynchronous and is honoured mid-frame: counter enable drops and no data_valid is produced.
- "last_edge" = (edge_cnt == latched_prescale-1). All bit decisions are taken only on last_edge.
- Config latch: prescale, par_en and par_typ are captured on the IDLE->START transition. Changes to these inputs mid-frame are ignored.
- IDLE:
  - If rx_in == 0 and prescale is 8 or 16 -> START. Clear par_err and stp_err on this transition.
  - Illegal prescale -> stay in IDLE.
- START:
  - On last_edge: sampled_bit == 0 -> DATA.
  - Otherwise the low pulse was a glitch -> IDLE. No error flag is set.
- DATA:
  - On last_edge, shift right with sampled_bit entering at the MSB (LSB-first reception).
  - When bit_cnt == DATA_WIDTH on that edge: go to PARITY if par_en, else STOP.
- PARITY:
  - On last_edge: expected = XOR(shift) for even, ~XOR(shift) for odd.
  - Register par_err = (sampled_bit != expected). Then -> STOP.
- STOP:
  - On last_edge: stp_err = ~sampled_bit.
  - If neither error is set: p_out <= shift and data_valid = 1 for exactly the next cycle.
  - Always -> IDLE.
- Outputs from state:
  - cnt_enable = dat_samp_en = (state != IDLE). These are registered Moore outputs.
  - The single IDLE cycle between frames clears the counter. Back-to-back frames are accepted with 1–2 cycles of start skew, which is within the half-bit margin.
- Latency: data_valid is asserted 1 cycle after the STOP last_edge.
- On error: p_out holds its previous value. The error flags hold until the next start detect.
- par_err and stp_err may both be 1 for the same frame.
- bit_cnt wrap-around beyond the frame length cannot occur, because the controller leaves DATA at bit_cnt == DATA_WIDTH.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - PRESCALE_8 = 5'd8 and PRESCALE_16 = 5'd16;
  - PAR_EVEN = 0 and PAR_ODD = 1.
- One natural sub-module, uart_rx_deser: the shift register plus p_out load. Inputs are shift_en, load_en and sampled_bit.

Test Plan:
1. prescale=8, par_en=1 even, frame 0xA5, parity bit 0, stop 1 -> data_valid single pulse, p_out=0xA5, par_err=0, stp_err=0.
2. prescale=16, par_en=1 odd, frame 0x3C with wrong parity bit 0 -> par_err=1, no data_valid, p_out unchanged.
3. prescale=8, par_en=0, frame 0x5A with stop bit 0 -> stp_err=1, no data_valid. Next good frame 0x01 -> stp_err cleared at start, p_out=0x01.
4. prescale=8, rx_in low 2 cycles then high (sampled_bit=1 at START last_edge) -> return to IDLE, cnt_enable low, no flags, no data_valid.
5. prescale=16, two back-to-back frames 0xFF, 0x00, no parity -> two data_valid pulses, p_out=0xFF then 0x00.
6. Assert RST low during DATA bit 4 -> all outputs 0 immediately; after release, frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// Frame states, legal oversampling ratios and parity selectors.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [4:0] PRESCALE_8  = 5'd8;
    localparam logic [4:0] PRESCALE_16 = 5'd16;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_deser.sv
// Receive shift register (LSB first) and output byte register.
// p_out is only loaded for error-free frames.
module uart_rx_deser #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  shift_en,
    input  logic                  load_en,
    input  logic                  sampled_bit,
    output logic [DATA_WIDTH-1:0] shift,
    output logic [DATA_WIDTH-1:0] p_out
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift <= '0;
            p_out <= '0;
        end else begin
            if (shift_en)
                shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
            if (load_en)
                p_out <= shift;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, data, parity, stop.
// Bit decisions are taken on the last oversample edge of each bit.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic [CNT_W-1:0]      prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [CNT_W-1:0]      edge_cnt,
    input  logic [CNT_W-1:0]      bit_cnt,
    input  logic                  sampled_bit,
    output logic                  cnt_enable,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] p_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    state_t state, nxt;

    logic [CNT_W-1:0]      pre_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [DATA_WIDTH-1:0] shift;

    logic legal_pre;
    logic last_edge;
    logic start_det;
    logic shift_en;
    logic par_chk;
    logic stp_chk;
    logic load_en;
    logic par_exp;

    assign legal_pre = (prescale == CNT_W'(PRESCALE_8)) ||
                       (prescale == CNT_W'(PRESCALE_16));
    assign last_edge = (edge_cnt == pre_q - CNT_W'(1));
    assign par_exp   = (par_typ_q == PAR_ODD) ? ~^shift : ^shift;
    // par_err already holds this frame's result when the stop bit lands
    assign load_en   = stp_chk && sampled_bit && !par_err;

    always_comb begin
        nxt       = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stp_chk   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_in && legal_pre) begin
                    nxt       = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (last_edge)
                    nxt = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (last_edge) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_WIDTH))
                        nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    par_chk = 1'b1;
                    nxt     = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    stp_chk = 1'b1;
                    nxt     = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            pre_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= nxt;
            data_valid <= load_en;
            if (start_det) begin
                pre_q     <= prescale;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                par_err   <= 1'b0;
                stp_err   <= 1'b0;
            end else begin
                if (par_chk)
                    par_err <= (sampled_bit != par_exp);
                if (stp_chk)
                    stp_err <= ~sampled_bit;
            end
        end
    end

    assign cnt_enable  = (state != IDLE);
    assign dat_samp_en = (state != IDLE);

    uart_rx_deser #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deser (
        .CLK         (CLK),
        .RST         (RST),
        .shift_en    (shift_en),
        .load_en     (load_en),
        .sampled_bit (sampled_bit),
        .shift       (shift),
        .p_out       (p_out)
    );

endmodule
